// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed number of wait states.
// Optional build macro DMEM_MISALIGN_ERR_EN: reject misaligned halves/words instead of aligning them.
//
// state  | meaning
// S_IDLE | ready; a request is accepted when req_valid is high
// S_WAIT | request registered, wait counter running down to terminal count
// S_RESP | response presented, held until resp_ready
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_type,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;

  logic [31:0] addr_q, wdata_q;
  logic [2:0]  type_q;
  logic        write_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, enter_resp, in_idle;
  logic [31:0] acc_addr, acc_wdata;
  logic [2:0]  acc_type;
  logic        acc_write;
  logic        is_half, is_word;
  logic        type_ok, range_ok, align_ok, acc_ok;
  logic [1:0]  eff_lo;
  logic [IDX_W-1:0] word_idx;
  logic [31:0] rd_word, ld_data, st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  st_be;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign accept     = req_valid && req_ready;
  assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = S_RESP;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      S_RESP: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge, before the registers load.
  assign in_idle   = (state == S_IDLE);
  assign acc_addr  = in_idle ? req_addr  : addr_q;
  assign acc_wdata = in_idle ? req_wdata : wdata_q;
  assign acc_type  = in_idle ? req_type  : type_q;
  assign acc_write = in_idle ? req_write : write_q;

  assign is_half  = (acc_type[1:0] == 2'b01);
  assign is_word  = (acc_type[1:0] == 2'b10);
  assign range_ok = (acc_addr[31:2] < 30'(DEPTH_WORDS));
  assign word_idx = acc_addr[IDX_W+1:2];

  always_comb begin
    type_ok = 1'b0;
    if (acc_write) begin
      type_ok = (acc_type == 3'b000) || (acc_type == 3'b001) || (acc_type == 3'b010);
    end else begin
      case (acc_type)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: type_ok = 1'b1;
        default:                                type_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    align_ok = 1'b1;
    eff_lo   = acc_addr[1:0];
`ifdef DMEM_MISALIGN_ERR_EN
    if (is_half && acc_addr[0])           align_ok = 1'b0;
    if (is_word && (acc_addr[1:0] != 0))  align_ok = 1'b0;
`else
    if (is_half) eff_lo = {acc_addr[1], 1'b0};
    if (is_word) eff_lo = 2'b00;
`endif
  end

  assign acc_ok  = type_ok && range_ok && align_ok;
  assign rd_word = mem[word_idx];

  always_comb begin
    case (eff_lo)
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = eff_lo[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_type)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    st_be   = 4'b0000;
    st_data = acc_wdata;
    case (acc_type[1:0])
      2'b00: begin
        st_be   = 4'b0001 << eff_lo;
        st_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << {eff_lo[1], 1'b0};
        st_data = {2{acc_wdata[15:0]}};
      end
      2'b10:   st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (enter_resp) begin
        err_q   <= !acc_ok;
        rdata_q <= (acc_ok && !acc_write) ? ld_data : 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      type_q  <= req_type;
      write_q <= req_write;
    end
  end

  // Storage is deliberately not reset; a reset before the commit edge drops a pending store.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_ok && acc_write) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized traffic
// checked against a byte-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_type;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mb [DEPTH*4];

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  t;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_type   (req_type),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: RISC-V load/store semantics on a little-endian byte array.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] t, output logic [31:0] rd, output logic e);
    int sz;
    bit legal;
    longint ea;
    logic [63:0] v;
    sz    = (t[1:0] == 2'd0) ? 1 : (t[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (t <= 3'd2) : (t inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    ea    = longint'(a);
    if (ea % sz != 0) begin
`ifdef DMEM_MISALIGN_ERR_EN
      legal = 1'b0;
`else
      ea = ea - (ea % sz);
`endif
    end
    if (a / 4 >= DEPTH) legal = 1'b0;
    rd = '0;
    e  = !legal;
    v  = '0;
    if (legal) begin
      if (w) begin
        for (int i = 0; i < sz; i++) mb[int'(ea) + i] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[int'(ea) + i];
        if (!t[2] && sz < 4 && v[8*sz-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*sz));
        rd = v[31:0];
      end
    end
  endtask

  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] t, input int hold, input bit garble,
                         output logic [31:0] rd, output logic e, output int lat,
                         output bit stable, output bit released);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_type = t;
    resp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    stable = 1'b1;
    released = 1'b0;
    @(negedge clk);
    lat = 1;
    if (garble) begin
      req_write = 1'b1; req_addr = 32'($urandom_range(0, DEPTH*4-1));
      req_wdata = $urandom; req_type = 3'b010;
    end else begin
      req_valid = 1'b0;
    end
    while (!resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) lat = -1;
    rd = resp_rdata;
    e  = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_rdata !== rd || resp_err !== e || req_ready) stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    released = !resp_valid && req_ready;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_type = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_checks++;
    if (resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", resp_rdata); end
    n_checks++;
    if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", resp_err); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_fill;
    logic [31:0] rd, erd, d;
    logic e, ee;
    int lat;
    bit st, rel;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      model(1'b1, 32'(i*4), d, 3'b010, erd, ee);
      run_txn(1'b1, 32'(i*4), d, 3'b010, 0, 1'b0, rd, e, lat, st, rel);
      n_checks++;
      if (e !== 1'b0 || rd !== 32'd0) begin
        n_fail++; $display("FAIL fill_sw[%0d]: got err %b rdata %h expected err 0 rdata 0", i, e, rd);
      end
    end
  endtask

  function automatic vec_t mkv(logic w, logic [31:0] a, logic [31:0] d, logic [2:0] t,
                               logic [31:0] er, logic ee);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.t = t; v.er = er; v.ee = ee;
    return v;
  endfunction

  task automatic test_directed;
    vec_t vq[$];
    logic [31:0] rd, mrd;
    logic e, me;
    int lat;
    bit st, rel;
    vq.push_back(mkv(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0));
    vq.push_back(mkv(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0));
    vq.push_back(mkv(1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0));
    vq.push_back(mkv(1'b0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 1'b0));
    vq.push_back(mkv(1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFFDEAD, 1'b0));
    vq.push_back(mkv(1'b0, 32'h10, 32'h0, 3'b101, 32'h0000BEEF, 1'b0));
    vq.push_back(mkv(1'b1, 32'h11, 32'h00000055, 3'b000, 32'h0, 1'b0));
    vq.push_back(mkv(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0));
`ifdef DMEM_MISALIGN_ERR_EN
    vq.push_back(mkv(1'b0, 32'h12, 32'h0, 3'b010, 32'h0, 1'b1));
`else
    vq.push_back(mkv(1'b0, 32'h12, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0));
`endif
    vq.push_back(mkv(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1));
    vq.push_back(mkv(1'b1, 32'h10, 32'h0, 3'b100, 32'h0, 1'b1));
    foreach (vq[k]) begin
      model(vq[k].w, vq[k].a, vq[k].d, vq[k].t, mrd, me);
      run_txn(vq[k].w, vq[k].a, vq[k].d, vq[k].t, 0, 1'b0, rd, e, lat, st, rel);
      n_checks++;
      if (rd !== vq[k].er || e !== vq[k].ee) begin
        n_fail++; $display("FAIL directed[%0d]: got rdata %h err %b expected rdata %h err %b", k, rd, e, vq[k].er, vq[k].ee);
      end
      n_checks++;
      if (lat !== WAITC + 1) begin
        n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", k, lat, WAITC + 1);
      end
    end
  endtask

  task automatic test_hold;
    logic [31:0] rd, erd;
    logic e, ee;
    int lat;
    bit st, rel;
    model(1'b0, 32'h10, 32'h0, 3'b010, erd, ee);
    run_txn(1'b0, 32'h10, 32'h0, 3'b010, 5, 1'b1, rd, e, lat, st, rel);
    n_checks++;
    if (rd !== erd || e !== ee) begin
      n_fail++; $display("FAIL hold_data: got rdata %h err %b expected rdata %h err %b", rd, e, erd, ee);
    end
    n_checks++;
    if (st !== 1'b1) begin n_fail++; $display("FAIL hold_stable: got %b expected 1", st); end
    n_checks++;
    if (rel !== 1'b1) begin n_fail++; $display("FAIL hold_release: got %b expected 1", rel); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd, erd;
    logic e, ee;
    int lat;
    bit st, rel;
    model(1'b1, 32'(DEPTH*4), 32'hCAFEF00D, 3'b010, erd, ee);
    run_txn(1'b1, 32'(DEPTH*4), 32'hCAFEF00D, 3'b010, 0, 1'b0, rd, e, lat, st, rel);
    n_checks++;
    if (e !== 1'b1 || rd !== 32'd0) begin
      n_fail++; $display("FAIL oor_store: got err %b rdata %h expected err 1 rdata 0", e, rd);
    end
    model(1'b0, 32'h0, 32'h0, 3'b010, erd, ee);
    run_txn(1'b0, 32'h0, 32'h0, 3'b010, 0, 1'b0, rd, e, lat, st, rel);
    n_checks++;
    if (rd !== erd || e !== 1'b0) begin
      n_fail++; $display("FAIL oor_no_alias: got rdata %h err %b expected rdata %h err 0", rd, e, erd);
    end
    run_txn(1'b0, 32'((DEPTH + 5) * 4), 32'h0, 3'b000, 0, 1'b0, rd, e, lat, st, rel);
    n_checks++;
    if (e !== 1'b1 || rd !== 32'd0) begin
      n_fail++; $display("FAIL oor_load: got err %b rdata %h expected err 1 rdata 0", e, rd);
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, erd, dummy;
    logic e, ee;
    int lat, guard;
    bit st, rel;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234; req_type = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait_state: got resp_valid %b req_ready %b expected 0 1", resp_valid, req_ready);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wait_no_resp: got %b expected 0", resp_valid); end
    model(1'b0, 32'h20, 32'h0, 3'b010, erd, ee);
    run_txn(1'b0, 32'h20, 32'h0, 3'b010, 0, 1'b0, rd, e, lat, st, rel);
    n_checks++;
    if (rd !== erd || e !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_no_commit: got rdata %h err %b expected rdata %h err 0", rd, e, erd);
    end
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h24; req_wdata = 32'h5555AAAA; req_type = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL rst_resp_reach: got %b expected 1", resp_valid); end
    model(1'b1, 32'h24, 32'h5555AAAA, 3'b010, dummy, ee);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL rst_resp_drop: got valid %b err %b rdata %h expected 0 0 0", resp_valid, resp_err, resp_rdata);
    end
    run_txn(1'b0, 32'h24, 32'h0, 3'b010, 0, 1'b0, rd, e, lat, st, rel);
    n_checks++;
    if (rd !== 32'h5555AAAA || e !== 1'b0) begin
      n_fail++; $display("FAIL rst_resp_kept: got rdata %h err %b expected rdata 5555aaaa err 0", rd, e);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, erd, a, d;
    logic [2:0] t;
    logic w, e, ee;
    int lat, hold;
    bit st, rel;
    for (int n = 0; n < 200; n++) begin
      w = 1'($urandom_range(0, 1));
      t = 3'($urandom_range(0, 7));
      d = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'(DEPTH*4 + $urandom_range(0, 4095)) | ($urandom_range(0, 1) == 1 ? 32'h8000_0000 : 32'h0);
      else a = 32'($urandom_range(0, DEPTH*4-1));
      hold = $urandom_range(0, 2);
      model(w, a, d, t, erd, ee);
      run_txn(w, a, d, t, hold, 1'b0, rd, e, lat, st, rel);
      n_checks++;
      if (rd !== erd || e !== ee) begin
        n_fail++; $display("FAIL random[%0d] w=%b t=%0d a=%h: got rdata %h err %b expected rdata %h err %b", n, w, t, a, rd, e, erd, ee);
      end
      n_checks++;
      if (lat !== WAITC + 1 || st !== 1'b1 || rel !== 1'b1) begin
        n_fail++; $display("FAIL random_handshake[%0d]: got lat %0d stable %b release %b expected %0d 1 1", n, lat, st, rel, WAITC + 1);
      end
    end
  endtask

  task automatic test_sweep;
    logic [31:0] rd, erd;
    logic e, ee;
    int lat;
    bit st, rel;
    for (int i = 0; i < DEPTH; i++) begin
      model(1'b0, 32'(i*4), 32'h0, 3'b010, erd, ee);
      run_txn(1'b0, 32'(i*4), 32'h0, 3'b010, 0, 1'b0, rd, e, lat, st, rel);
      n_checks++;
      if (rd !== erd || e !== 1'b0) begin
        n_fail++; $display("FAIL sweep[%0d]: got rdata %h err %b expected rdata %h err 0", i, rd, e, erd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_hold();
    test_out_of_range();
    test_reset_abort();
    test_random();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words of storage.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of added wait states between request acceptance and response (0..15).
REQ-003 clk  input  1  single clock; all state updates on posedge(clk).
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a data-memory request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address, taken from the execute-stage ALU result.
REQ-009 req_wdata  input  32  store data; bytes/halves taken from the low bits.
REQ-010 req_type  input  3  RISC-V funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator accepts the response.
REQ-013 resp_rdata  output  32  load result, already extended; 0 for stores and errors.
REQ-014 resp_err  output  1  request rejected (misaligned, out of range, or illegal type).

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on the cycle req_valid && req_ready, registering addr, wdata, type and write.
REQ-017 After acceptance with WAIT_CYCLES > 0, SHALL enter WAIT and count down WAIT_CYCLES cycles, then enter RESP.
REQ-018 After acceptance with WAIT_CYCLES = 0, SHALL enter RESP directly; resp_valid is then asserted on the cycle after acceptance.
REQ-019 SHALL commit a legal store to memory on the transition into RESP, and SHALL compute load data on that same transition.
REQ-020 In RESP, SHALL hold resp_valid = 1 and hold resp_rdata and resp_err stable until resp_ready = 1.
REQ-021 SHALL return to IDLE on the cycle after resp_valid && resp_ready, and SHALL deassert resp_valid in that cycle.
REQ-022 SHALL have no back-to-back overlap: at most one request is outstanding at any time.
REQ-023 Loads: LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; the byte/half is selected by addr[1:0] (little-endian).
REQ-024 Stores: SB SHALL write one byte lane; SH SHALL write two byte lanes; SW SHALL write all four lanes; all other lanes are unchanged.
REQ-025 Word index addr[31:2] >= DEPTH_WORDS SHALL give resp_err = 1, with no write and resp_rdata = 0.
REQ-026 Load types 011/110/111 and store types other than 000/001/010 SHALL give resp_err = 1, with no write.
REQ-027 Misalignment handling SHALL be per REQ-034/REQ-035.
REQ-028 req_* inputs SHALL be ignored while not in IDLE.

Reset
REQ-029 rst SHALL force state = IDLE, wait counter = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-030 req_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 rst asserted while in WAIT SHALL abandon the pending request; a pending store SHALL NOT be committed.
REQ-033 rst asserted while in RESP SHALL drop the response; a store already committed SHALL remain.

Configuration
REQ-034 With DMEM_MISALIGN_ERR_EN defined, the following SHALL be errors: LH/LHU/SH with addr[0] = 1, and LW/SW with addr[1:0] != 0. Each SHALL give resp_err = 1, with no write and resp_rdata = 0.
REQ-035 Without DMEM_MISALIGN_ERR_EN, SHALL force addr[0] to 0 for halves and addr[1:0] to 0 for words, and perform the access with resp_err = 0.

Verification
REQ-036 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_rdata 0xDEADBEEF, resp_err 0, resp_valid exactly WAIT_CYCLES+1 cycles after acceptance.
REQ-037 After REQ-036: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-038 SB 0x11 data 0x00000055 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF.
REQ-039 LW 0x12 -> with DMEM_MISALIGN_ERR_EN: resp_err 1, rdata 0. Without it: rdata = word at 0x10, resp_err 0.
REQ-040 Load resp held with resp_ready = 0 for 5 cycles -> resp_valid and rdata stable, req_ready 0; req_ready 1 on the cycle after resp_ready = 1.
REQ-041 Two cases: SW to word index DEPTH_WORDS -> resp_err 1, memory unchanged; rst pulsed during WAIT of SW 0x20 data 0x1234 -> later LW 0x20 returns the prior value.
